uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx_queue.sv | 157 +++++++++++++++
 tb/tb_uart_tx_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: FSM state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam int   DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue for the UART transmitter: power-of-two depth, dual pointers with a wrap bit.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Equal indices: the wrap bit tells a full queue from an empty one.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head is read combinationally so the transmitter can pop and load in one cycle.
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_tx_queue.sv
// Queued UART transmitter: edge-triggered byte intake, FIFO, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 520,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sender_ready,
  input  logic [7:0] w_data,
  output logic       sender_sending,
  output logic       txd,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int TW         = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

  tx_state_t     state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;
  logic          ready_reg;
  logic          overflow_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic       accept;
  logic       push;
  logic       pop;
  logic       bit_end;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;

  always_comb begin
    accept  = sender_ready & ~ready_reg;
    push    = accept & ~fifo_full;
    bit_end = (timer_reg == TIMER_LAST);
    pop     = ~fifo_empty &&
              ((state_reg == ST_IDLE) || (state_reg == ST_STOP && bit_end));
  end

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(w_data),
    .pop      (pop),
    .pop_data (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= UART_IDLE_LEVEL;
      ready_reg    <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      ready_reg <= sender_ready;
      if (accept && fifo_full) overflow_reg <= 1'b1;

      // The timer restarts from zero on every bit boundary and rests at zero in IDLE.
      if (state_reg == ST_IDLE || bit_end) timer_reg <= '0;
      else                                 timer_reg <= timer_reg + TW'(1);

      case (state_reg)
        ST_IDLE: begin
          txd_reg <= UART_IDLE_LEVEL;
          if (pop) begin
            state_reg <= ST_START;
            txd_reg   <= START_LEVEL;
            shift_reg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^fifo_rd_data;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_reg   <= ST_DATA;
            bit_idx_reg <= '0;
            txd_reg     <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= ST_PARITY;
              txd_reg   <= parity_reg;
`else
              state_reg <= ST_STOP;
              txd_reg   <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              txd_reg     <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_reg <= ST_STOP;
            txd_reg   <= UART_IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            // A waiting byte starts immediately, with no idle bit in between.
            if (pop) begin
              state_reg <= ST_START;
              txd_reg   <= START_LEVEL;
              shift_reg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
              parity_reg <= ^fifo_rd_data;
`endif
            end else begin
              state_reg <= ST_IDLE;
              txd_reg   <= UART_IDLE_LEVEL;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign txd            = txd_reg;
  assign overflow       = overflow_reg;
  assign sender_sending = (state_reg != ST_IDLE) || ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios plus random traffic against a frame-timing model.
module tb_uart_tx_queue;

  localparam int CPH   = 4;
  localparam int DEPTH = 16;
  localparam int BIT   = 2 * CPH;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = NBITS * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sender_ready = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       sender_sending;
  logic       txd;
  logic       fifo_full;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  uart_tx_queue #(
    .CLK_PER_HALF_BIT(CPH),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sender_ready  (sender_ready),
    .w_data        (w_data),
    .sender_sending(sender_sending),
    .txd           (txd),
    .fifo_full     (fifo_full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each offered byte gets an accept cycle; a kept byte's frame starts
  // two cycles later or right after the previous frame, whichever is later.
  typedef struct {
    int         acc;
    int         start;
    logic [7:0] data;
    bit         kept;
  } ent_t;

  ent_t ents[$];
  int   rst_cycles[$];

  function automatic int latest_rst(input int t);
    int r = -1;
    foreach (rst_cycles[i]) if (rst_cycles[i] < t && rst_cycles[i] > r) r = rst_cycles[i];
    return r;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    logic v;
    if (b == 0)                 v = 1'b0;
    else if (b <= 8)            v = d[b-1];
    else if (PAR_EN && b == 9)  v = ^d;
    else                        v = 1'b1;
    return v;
  endfunction

  function automatic int occupancy(input int t);
    int rr = latest_rst(t);
    int n  = 0;
    foreach (ents[i])
      if (ents[i].kept && ents[i].acc > rr && ents[i].acc + 1 <= t && t <= ents[i].start - 1) n++;
    return n;
  endfunction

  function automatic void model_accept(input int t, input logic [7:0] d);
    int   rr   = latest_rst(t);
    int   prev = -1000000;
    ent_t e;
    foreach (ents[i])
      if (ents[i].kept && ents[i].acc > rr && ents[i].start > prev) prev = ents[i].start;
    e.acc   = t;
    e.data  = d;
    e.kept  = (occupancy(t) < DEPTH);
    e.start = (t + 2 > prev + FRAME) ? t + 2 : prev + FRAME;
    ents.push_back(e);
  endfunction

  function automatic logic exp_txd(input int t);
    int   rr = latest_rst(t);
    logic v  = 1'b1;
    foreach (ents[i])
      if (ents[i].kept && ents[i].acc > rr && t >= ents[i].start && t < ents[i].start + FRAME)
        v = exp_bit(ents[i].data, (t - ents[i].start) / BIT);
    return v;
  endfunction

  function automatic logic exp_sending(input int t);
    int   rr = latest_rst(t);
    logic v  = 1'b0;
    foreach (ents[i])
      if (ents[i].kept && ents[i].acc > rr && ents[i].acc + 1 <= t && t < ents[i].start + FRAME)
        v = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ovf(input int t);
    int   rr = latest_rst(t);
    logic v  = 1'b0;
    foreach (ents[i]) if (!ents[i].kept && ents[i].acc > rr && ents[i].acc < t) v = 1'b1;
    return v;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    rst_cycles.push_back(cyc);
    repeat (n - 1) begin
      @(negedge clk);
      rst_cycles.push_back(cyc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one byte at the current cycle; returns with sender_ready low for one cycle.
  task automatic pulse(input logic [7:0] b, input int hold);
    sender_ready = 1'b1;
    w_data       = b;
    model_accept(cyc, b);
    repeat (hold) begin
      @(negedge clk);
      w_data = 8'($urandom);
    end
    sender_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_fall(input int limit, output int fc);
    int g = 0;
    while (sender_sending !== 1'b0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (g >= limit) begin
      fails++;
      $display("FAIL drain_timeout: sender_sending still %b after %0d cycles, required 0", sender_sending, limit);
    end
    fc = cyc;
  endtask

  task automatic test_reset();
    do_reset(3);
    check_en = 1'b1;
    tests += 4;
    if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b, required 1", txd); end
    if (sender_sending !== 1'b0) begin fails++; $display("FAIL reset_sending: got %b, required 0", sender_sending); end
    if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    $display("[TB] reset done at cycle %0d", cyc);
  endtask

  task automatic test_single();
    int t;
    int fc;
    t = cyc;
    sender_ready = 1'b1;
    w_data       = 8'h55;
    model_accept(t, 8'h55);
    @(negedge clk);
    sender_ready = 1'b0;
    tests += 2;
    if (sender_sending !== 1'b1) begin fails++; $display("FAIL single_sending_n1: got %b, required 1", sender_sending); end
    if (txd !== 1'b1) begin fails++; $display("FAIL single_txd_n1: got %b, required 1", txd); end
    @(negedge clk);
    tests++;
    if (txd !== 1'b0) begin fails++; $display("FAIL single_start_n2: got %b, required 0", txd); end
    for (int b = 1; b < NBITS; b++) begin
      wait_until(t + 2 + b * BIT + BIT / 2);
      tests++;
      if (txd !== exp_bit(8'h55, b))
        begin fails++; $display("FAIL single_bit%0d: got %b, required %b", b, txd, exp_bit(8'h55, b)); end
    end
    wait_fall(4 * FRAME, fc);
    tests++;
    if (fc !== t + 2 + FRAME) begin fails++; $display("FAIL single_fall: cycle %0d, required %0d", fc, t + 2 + FRAME); end
    $display("[TB] single 0x55 accepted cycle %0d, sending fell cycle %0d", t, fc);
  endtask

  task automatic test_held_level();
    int t;
    int hi = 0;
    t = cyc;
    sender_ready = 1'b1;
    w_data       = 8'hA3;
    model_accept(t, 8'hA3);
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k == 200)     sender_ready = 1'b0;
      else if (k < 200) w_data = 8'($urandom);
      if (sender_sending === 1'b1) hi++;
    end
    tests++;
    if (hi !== FRAME + 1) begin fails++; $display("FAIL held_one_frame: busy %0d cycles, required %0d", hi, FRAME + 1); end
    $display("[TB] held level 0xA3: busy %0d cycles", hi);
  endtask

  task automatic test_overflow();
    int t0;
    int fc;
    t0 = cyc;
    pulse(8'hC5, 1);
    for (int i = 1; i <= 17; i++) begin
      pulse(8'($urandom), 1);
      if (i == 15) begin
        tests++;
        if (fifo_full !== 1'b0) begin fails++; $display("FAIL ovf_full_at15: got %b, required 0", fifo_full); end
      end
      if (i == 16) begin
        tests += 2;
        if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full_at16: got %b, required 1", fifo_full); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b, required 0", overflow); end
      end
      if (i == 17) begin
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_at17: got %b, required 1", overflow); end
      end
    end
    wait_fall(20 * FRAME, fc);
    tests++;
    if (fc !== t0 + 2 + 17 * FRAME)
      begin fails++; $display("FAIL ovf_back_to_back: fell cycle %0d, required %0d", fc, t0 + 2 + 17 * FRAME); end
    $display("[TB] overflow burst: 17 frames, sending fell cycle %0d", fc);
  endtask

  task automatic test_reset_midframe();
    int t;
    int t2;
    int fc;
    t = cyc;
    pulse(8'hF0, 1);
    wait_until(t + 2 + 4 * BIT + BIT / 2);
    tests++;
    if (txd !== 1'b0) begin fails++; $display("FAIL mid_bit3: got %b, required 0", txd); end
    rst = 1'b1;
    rst_cycles.push_back(cyc);
    @(negedge clk);
    rst = 1'b0;
    tests += 4;
    if (txd !== 1'b1) begin fails++; $display("FAIL mid_rst_txd: got %b, required 1", txd); end
    if (sender_sending !== 1'b0) begin fails++; $display("FAIL mid_rst_sending: got %b, required 0", sender_sending); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL mid_rst_overflow: got %b, required 0", overflow); end
    if (fifo_full !== 1'b0) begin fails++; $display("FAIL mid_rst_full: got %b, required 0", fifo_full); end
    t2 = cyc;
    pulse(8'h12, 1);
    wait_fall(4 * FRAME, fc);
    tests++;
    if (fc !== t2 + 2 + FRAME) begin fails++; $display("FAIL mid_next_frame: fell cycle %0d, required %0d", fc, t2 + 2 + FRAME); end
    $display("[TB] reset mid-frame, then 0x12 sent, fell cycle %0d", fc);
  endtask

  task automatic test_push_at_stop();
    int t;
    int c;
    int fc;
    t = cyc;
    pulse(8'h3C, 1);
    pulse(8'hB7, 1);
    wait_until(t + 1 + FRAME);
    c = cyc;
    pulse(8'h69, 1);
    tests += 2;
    if (fifo_full !== 1'b0) begin fails++; $display("FAIL pp_full: got %b, required 0", fifo_full); end
    if (sender_sending !== 1'b1) begin fails++; $display("FAIL pp_sending: got %b, required 1", sender_sending); end
    wait_fall(6 * FRAME, fc);
    tests++;
    if (fc !== t + 2 + 3 * FRAME) begin fails++; $display("FAIL pp_three_frames: fell cycle %0d, required %0d", fc, t + 2 + 3 * FRAME); end
    $display("[TB] push at pop cycle %0d, sending fell cycle %0d", c, fc);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par   [2];
    int t;
    int fc;
    bytes[0] = 8'h07; par[0] = 1'b1;
    bytes[1] = 8'h03; par[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t = cyc;
      pulse(bytes[i], 1);
      wait_until(t + 2 + 9 * BIT + BIT / 2);
      tests++;
      if (txd !== par[i]) begin fails++; $display("FAIL parity_%h: got %b, required %b", bytes[i], txd, par[i]); end
      wait_fall(4 * FRAME, fc);
      tests++;
      if (fc !== t + 2 + 88) begin fails++; $display("FAIL parity_len_%h: fell cycle %0d, required %0d", bytes[i], fc, t + 90); end
      $display("[TB] parity byte %h, sending fell cycle %0d", bytes[i], fc);
    end
  endtask
`endif

  task automatic test_random();
    int gap;
    int fc;
    for (int it = 0; it < 40; it++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 200) : $urandom_range(0, 6);
      if (it == 20) do_reset(2);
      pulse(8'($urandom), $urandom_range(1, 10));
      repeat (gap) @(negedge clk);
      $display("[TB] random byte %0d offered, gap %0d, occupancy %0d", it, gap, occupancy(cyc));
    end
    wait_fall(50 * FRAME, fc);
    $display("[TB] random traffic drained at cycle %0d", fc);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (check_en) begin
          tests += 4;
          if (txd !== exp_txd(cyc))
            begin fails++; $display("FAIL line_txd cycle %0d: got %b, required %b", cyc, txd, exp_txd(cyc)); end
          if (sender_sending !== exp_sending(cyc))
            begin fails++; $display("FAIL line_sending cycle %0d: got %b, required %b", cyc, sender_sending, exp_sending(cyc)); end
          if (fifo_full !== (occupancy(cyc) == DEPTH))
            begin fails++; $display("FAIL line_full cycle %0d: got %b, required %b", cyc, fifo_full, occupancy(cyc) == DEPTH); end
          if (overflow !== exp_ovf(cyc))
            begin fails++; $display("FAIL line_overflow cycle %0d: got %b, required %b", cyc, overflow, exp_ovf(cyc)); end
        end
      end
    join_none

    test_reset();
    test_single();
    test_held_level();
    test_overflow();
    test_reset_midframe();
    test_push_at_stop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
